// File: rtl/reaction_pkg.sv
// ---------------------------------------------------------------------------
// reaction_pkg
//   Shared definitions for the multi-player reaction timer:
//   - state_t      : controller FSM states
//   - LED_ON/OFF   : LED bar patterns
//   - wait_width() : wait-counter width that holds MIN_WAIT + RandomValue
//                    without wrapping
//   - idx_width()  : player-index width, never narrower than one bit
// ---------------------------------------------------------------------------
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    LIT,
    REPORT,
    ACKWAIT
  } state_t;

  localparam logic [7:0] LED_ON  = 8'hFF;
  localparam logic [7:0] LED_OFF = 8'h00;

  // One bit wider than the larger addend, so the sum of the floor and the
  // random offset always fits.
  function automatic int wait_width(input int rand_w, input int min_wait);
    int floor_w;
    floor_w = $clog2(min_wait + 1);
    return ((rand_w > floor_w) ? rand_w : floor_w) + 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reaction_tick_gen.sv
// ---------------------------------------------------------------------------
// reaction_tick_gen
//   Prescaler producing a one-cycle timing tick every TICK_DIV clocks.
//   A synchronous restart realigns the phase so the first tick lands exactly
//   TICK_DIV cycles after the restart cycle. TICK_DIV=1 ticks every cycle.
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   restart  in   synchronous phase restart
//   tick     out  one-cycle timing pulse
// ---------------------------------------------------------------------------
module reaction_tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multi_reaction_timer.sv
// ---------------------------------------------------------------------------
// multi_reaction_timer
//   N-player reaction-time game controller. A Start edge arms a round and
//   loads a wait of MIN_WAIT + RandomValue ticks; when it expires the LED bar
//   lights and every player's first press is timed against a shared count.
//   Early presses mark a cheat, players still silent at SLOW_LIMIT are marked
//   slow, the earliest capture (lowest index on a tie) is the winner, and the
//   results are offered to the LCD driver with a 4-phase LCDUpdate/LCDAck
//   handshake.
// Optional feature (macro BEST_TIME_EN)
//   Adds BestTime/BestPlayer: the best winning time seen since reset and its
//   holder. Ties keep the earlier holder.
// Ports
//   Clk, Rst       clock, asynchronous active-low reset
//   Start          rising edge arms a round (ignored outside IDLE)
//   Press          per-player buttons, rising edge counts
//   RandomValue    random wait offset, sampled on the arming edge
//   LED            8'hFF while lit, else 8'h00
//   Wait           high during the random wait
//   ReactionTime   player i at [i*TIME_W +: TIME_W]
//   Valid/Cheat/Slow  per-player result flags
//   Winner/WinnerValid  fastest valid player
//   LCDUpdate/LCDAck    result handshake with the display
//   BestTime/BestPlayer (BEST_TIME_EN only)
// ---------------------------------------------------------------------------
module multi_reaction_timer
  import reaction_pkg::*;
#(
  parameter  int NUM_PLAYERS = 4,
  parameter  int TIME_W      = 10,
  parameter  int RAND_W      = 13,
  parameter  int MIN_WAIT    = 1000,
  parameter  int SLOW_LIMIT  = 500,
  parameter  int TICK_DIV    = 1,
  localparam int WIN_W       = idx_width(NUM_PLAYERS)
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          Start,
  input  logic [NUM_PLAYERS-1:0]        Press,
  input  logic [RAND_W-1:0]             RandomValue,
  output logic [7:0]                    LED,
  output logic                          Wait,
  output logic [NUM_PLAYERS*TIME_W-1:0] ReactionTime,
  output logic [NUM_PLAYERS-1:0]        Valid,
  output logic [NUM_PLAYERS-1:0]        Cheat,
  output logic [NUM_PLAYERS-1:0]        Slow,
  output logic [WIN_W-1:0]              Winner,
  output logic                          WinnerValid,
  output logic                          LCDUpdate,
`ifdef BEST_TIME_EN
  output logic [TIME_W-1:0]             BestTime,
  output logic [WIN_W-1:0]              BestPlayer,
`endif
  input  logic                          LCDAck
);

  localparam int WAIT_W = wait_width(RAND_W, MIN_WAIT);

  state_t                   state;
  logic                     start_q;
  logic [NUM_PLAYERS-1:0]   press_q;
  logic [WAIT_W-1:0]        wait_cnt;
  logic [TIME_W-1:0]        lit_count;

  logic                     tick;
  logic                     start_edge;
  logic                     arm;
  logic                     at_limit;
  logic [NUM_PLAYERS-1:0]   press_edge;
  logic [NUM_PLAYERS-1:0]   cheat_hit;
  logic [NUM_PLAYERS-1:0]   capture;
  logic [NUM_PLAYERS-1:0]   slow_hit;
  logic [NUM_PLAYERS-1:0]   resolved_next;
  logic [WIN_W-1:0]         first_idx;

  assign start_edge = Start & ~start_q;
  assign arm        = start_edge && (state == IDLE);
  assign at_limit   = (lit_count == TIME_W'(SLOW_LIMIT));

  reaction_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (Clk),
    .rst_n   (Rst),
    .restart (arm),
    .tick    (tick)
  );

  // Per-player decode. A player is locked once it has cheated, been
  // captured or been declared slow; the SLOW_LIMIT cycle wins over a press.
  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_player
    logic locked;
    assign locked           = Cheat[i] | Valid[i] | Slow[i];
    assign press_edge[i]    = Press[i] & ~press_q[i];
    assign cheat_hit[i]     = (state == WAIT) & press_edge[i];
    assign capture[i]       = (state == LIT) & press_edge[i] & ~locked & ~at_limit;
    assign slow_hit[i]      = (state == LIT) & at_limit & ~locked;
    assign resolved_next[i] = Cheat[i] | cheat_hit[i] | Valid[i] | capture[i]
                            | Slow[i] | slow_hit[i];
  end

  // Lowest-index capturing player, used to break ties.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (capture[i]) first_idx = WIN_W'(i);
    end
  end

`ifdef BEST_TIME_EN
  logic [TIME_W-1:0] winner_time;
  assign winner_time = ReactionTime[Winner*TIME_W +: TIME_W];
`endif

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; later assignments in this block override earlier ones,
  // which is how the arming edge clears the per-player results.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      press_q      <= '0;
      wait_cnt     <= '0;
      lit_count    <= '0;
      LED          <= LED_OFF;
      Wait         <= 1'b0;
      ReactionTime <= '0;
      Valid        <= '0;
      Cheat        <= '0;
      Slow         <= '0;
      Winner       <= '0;
      WinnerValid  <= 1'b0;
      LCDUpdate    <= 1'b0;
`ifdef BEST_TIME_EN
      BestTime     <= '1;
      BestPlayer   <= '0;
`endif
    end else begin
      start_q <= Start;
      press_q <= Press;

      // Per-player results; the decode already gates these by state.
      Cheat <= Cheat | cheat_hit;
      Valid <= Valid | capture;
      Slow  <= Slow | slow_hit;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (capture[i]) begin
          ReactionTime[i*TIME_W +: TIME_W] <= lit_count;
        end else if (slow_hit[i]) begin
          ReactionTime[i*TIME_W +: TIME_W] <= TIME_W'(SLOW_LIMIT);
        end
      end
      if ((capture != '0) && !WinnerValid) begin
        Winner      <= first_idx;
        WinnerValid <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start_edge) begin
            state        <= WAIT;
            Wait         <= 1'b1;
            wait_cnt     <= WAIT_W'(MIN_WAIT) + WAIT_W'(RandomValue);
            ReactionTime <= '0;
            Valid        <= '0;
            Cheat        <= '0;
            Slow         <= '0;
            Winner       <= '0;
            WinnerValid  <= 1'b0;
          end
        end

        WAIT: begin
          if (&resolved_next) begin
            // Everyone cheated: report straight away, LED never lights.
            state     <= REPORT;
            Wait      <= 1'b0;
            LCDUpdate <= 1'b1;
          end else if (tick) begin
            // Lighting on the tick that would bring the count to zero puts
            // LED-on exactly MIN_WAIT + RandomValue ticks after arming.
            if (wait_cnt < WAIT_W'(2)) begin
              state     <= LIT;
              Wait      <= 1'b0;
              LED       <= LED_ON;
              lit_count <= '0;
            end else begin
              wait_cnt <= wait_cnt - 1'b1;
            end
          end
        end

        LIT: begin
          if (tick && (lit_count != '1)) begin
            lit_count <= lit_count + 1'b1;
          end
          if (&resolved_next) begin
            state     <= REPORT;
            LED       <= LED_OFF;
            LCDUpdate <= 1'b1;
          end
        end

        REPORT: begin
`ifdef BEST_TIME_EN
          if (WinnerValid && (winner_time < BestTime)) begin
            BestTime   <= winner_time;
            BestPlayer <= Winner;
          end
`endif
          if (LCDAck) begin
            LCDUpdate <= 1'b0;
            state     <= ACKWAIT;
          end
        end

        ACKWAIT: begin
          if (!LCDAck) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_reaction_timer.sv
// ---------------------------------------------------------------------------
// tb_multi_reaction_timer
//   Directed bench: NUM_PLAYERS=4, TICK_DIV=1, MIN_WAIT=10, SLOW_LIMIT=50,
//   RandomValue=5. Inputs change 1 time unit after the rising edge and
//   outputs are read at the same point. "cur" tracks the shared LIT count
//   value that the next rising edge will sample.
// ---------------------------------------------------------------------------
module tb_multi_reaction_timer;

  localparam int NP = 4;
  localparam int TW = 10;
  localparam int RW = 13;

  logic           Clk = 1'b0;
  logic           Rst = 1'b0;
  logic           Start = 1'b0;
  logic           LCDAck = 1'b0;
  logic [NP-1:0]  Press = '0;
  logic [RW-1:0]  RandomValue = 13'd5;
  logic [7:0]     LED;
  logic           Wait;
  logic [NP*TW-1:0] ReactionTime;
  logic [NP-1:0]  Valid;
  logic [NP-1:0]  Cheat;
  logic [NP-1:0]  Slow;
  logic [1:0]     Winner;
  logic           WinnerValid;
  logic           LCDUpdate;
`ifdef BEST_TIME_EN
  logic [TW-1:0]  BestTime;
  logic [1:0]     BestPlayer;
`endif

  int checks = 0;
  int errors = 0;
  int cur    = 0;

  always #5 Clk = ~Clk;

  multi_reaction_timer #(
    .NUM_PLAYERS (NP),
    .TIME_W      (TW),
    .RAND_W      (RW),
    .MIN_WAIT    (10),
    .SLOW_LIMIT  (50),
    .TICK_DIV    (1)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Start        (Start),
    .Press        (Press),
    .RandomValue  (RandomValue),
    .LED          (LED),
    .Wait         (Wait),
    .ReactionTime (ReactionTime),
    .Valid        (Valid),
    .Cheat        (Cheat),
    .Slow         (Slow),
    .Winner       (Winner),
    .WinnerValid  (WinnerValid),
    .LCDUpdate    (LCDUpdate),
`ifdef BEST_TIME_EN
    .BestTime     (BestTime),
    .BestPlayer   (BestPlayer),
`endif
    .LCDAck       (LCDAck)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic advance_to(input int c);
    while (cur < c) begin
      tick();
      cur++;
    end
  endtask

  task automatic press_at(input int c, input logic [NP-1:0] m);
    advance_to(c);
    Press = Press | m;
    tick();
    cur++;
  endtask

  // Arming edge plus 15 further edges: the LED lights on the 15th.
  task automatic arm_to_lit(input string tag);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (14) tick();
    tick();
    check(tag, LED, 8'hFF);
    cur = 0;
  endtask

  task automatic ack_round(input string tag);
    check({tag, "_lcd_up"}, LCDUpdate, 1'b1);
    LCDAck = 1'b1;
    tick();
    check({tag, "_lcd_drop"}, LCDUpdate, 1'b0);
    LCDAck = 1'b0;
    tick();
    tick();
    Press = '0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset ----------------
    repeat (3) tick();
    check("rst_flags", {LED, Wait, Valid, Cheat, Slow, Winner, WinnerValid, LCDUpdate}, 25'd0);
    check("rst_rt", ReactionTime, 40'd0);
    Rst = 1'b1;
    tick();
    check("idle_flags", {LED, Wait, LCDUpdate}, 10'd0);

    // ---------------- 1: wait timing ----------------
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("t1_wait_hi", Wait, 1'b1);
    check("t1_led_off", LED, 8'h00);
    for (int j = 1; j <= 14; j++) begin
      tick();
      check("t1_still_dark", {LED, LCDUpdate, Valid}, 13'd0);
    end
    check("t1_wait_14", Wait, 1'b1);
    tick();
    check("t1_led_on", LED, 8'hFF);
    check("t1_wait_lo", Wait, 1'b0);
    cur = 0;

    // ---------------- 2: four captures ----------------
    press_at(7, 4'b0010);
    check("t2_first_winner", {WinnerValid, Winner}, 3'b101);
    check("t2_rt1", ReactionTime[19:10], 10'd7);
    press_at(9, 4'b0001);
    press_at(12, 4'b0100);
    check("t2_mid_valid", Valid, 4'b0111);
    check("t2_mid_lcd", LCDUpdate, 1'b0);
    press_at(20, 4'b1000);
    check("t2_rt", ReactionTime, {10'd20, 10'd12, 10'd7, 10'd9});
    check("t2_valid", Valid, 4'hF);
    check("t2_winner", {WinnerValid, Winner}, 3'b101);
    check("t2_led_off", LED, 8'h00);
    ack_round("t2");
    check("t2_hold_idle", Valid, 4'hF);

    // ---------------- 3: cheat in WAIT ----------------
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("t3_cleared", {Valid, WinnerValid}, 5'd0);
    repeat (3) tick();
    Press = 4'b0100;
    tick();
    check("t3_cheat", Cheat, 4'b0100);
    check("t3_wait_still", {Wait, LED}, 9'h100);
    Press = '0;
    repeat (10) tick();
    check("t3_dark_14", LED, 8'h00);
    tick();
    check("t3_lit", LED, 8'hFF);
    cur = 0;
    press_at(2, 4'b0100);
    check("t3_cheater_ignored", {Valid, WinnerValid}, 5'd0);
    Press = '0;
    tick();
    cur++;
    press_at(5, 4'b1000);
    check("t3_winner", {WinnerValid, Winner}, 3'b111);
    press_at(6, 4'b0010);
    LCDAck = 1'b1;   // already high when REPORT is entered
    press_at(8, 4'b0001);
    check("t3_report", {LCDUpdate, Valid, Cheat}, 9'b1_1011_0100);
    check("t3_rt", ReactionTime, {10'd5, 10'd0, 10'd6, 10'd8});
    check("t3_winner_final", Winner, 2'd3);
    tick();
    check("t3_early_ack", LCDUpdate, 1'b0);
    LCDAck = 1'b0;
    tick();
    tick();
    Press = '0;
    tick();

    // ---------------- 4: simultaneous presses ----------------
    arm_to_lit("t4_lit");
    press_at(4, 4'b1001);
    check("t4_tie", {ReactionTime[39:30], ReactionTime[9:0]}, {10'd4, 10'd4});
    check("t4_winner", {WinnerValid, Winner}, 3'b100);
    press_at(6, 4'b0010);
    press_at(7, 4'b0100);
    check("t4_winner_kept", Winner, 2'd0);
    ack_round("t4");

    // ---------------- 5: slow players ----------------
    arm_to_lit("t5_lit");
    press_at(30, 4'b0010);
    check("t5_one", {Valid, WinnerValid, Winner}, 7'b0010_1_01);
    advance_to(50);
    check("t5_before_limit", {Slow, LCDUpdate}, 5'd0);
    press_at(50, 4'b0001);   // press on the limit cycle counts as slow
    check("t5_slow", Slow, 4'b1101);
    check("t5_valid", Valid, 4'b0010);
    check("t5_rt", ReactionTime, {10'd50, 10'd50, 10'd30, 10'd50});
    check("t5_winner", {WinnerValid, Winner}, 3'b101);
    ack_round("t5");

    // ---------------- 6: reset mid-LIT ----------------
    arm_to_lit("t6_lit");
    press_at(3, 4'b0001);
    Start = 1'b1;
    tick();
    check("t6_start_ignored", {LED, Wait, Valid}, {8'hFF, 1'b0, 4'b0001});
    Start = 1'b0;
    tick();
    #2;
    Rst = 1'b0;
    #1;
    check("t6_async_flags", {LED, Wait, Valid, Cheat, Slow, Winner, WinnerValid, LCDUpdate}, 25'd0);
    check("t6_async_rt", ReactionTime, 40'd0);
    Press = '0;
    #1;
    Rst = 1'b1;
    tick();
    tick();
    check("t6_idle_after", {LED, Wait, LCDUpdate}, 10'd0);

`ifdef BEST_TIME_EN
    // ---------------- best time: rounds of 9, 7, 7 ----------------
    check("bt_reset", {BestTime, BestPlayer}, {10'h3FF, 2'd0});
    arm_to_lit("bt1_lit");
    press_at(9, 4'b1111);
    ack_round("bt1");
    check("bt1", {BestTime, BestPlayer}, {10'd9, 2'd0});
    arm_to_lit("bt2_lit");
    press_at(7, 4'b0010);
    press_at(8, 4'b1101);
    ack_round("bt2");
    check("bt2", {BestTime, BestPlayer}, {10'd7, 2'd1});
    arm_to_lit("bt3_lit");
    press_at(7, 4'b0100);
    press_at(8, 4'b1011);
    ack_round("bt3");
    check("bt3_tie_keeps", {BestTime, BestPlayer}, {10'd7, 2'd1});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
